// File: rtl/itch_axil_snapshot_reader.sv
// AXI4-Lite read-only master: polls the ITCH parser's latched-result bank and
// emits one record per new, untorn snapshot on a valid/ready record port.
module itch_axil_snapshot_reader #(
   parameter int C_M_AXI_ADDR_WIDTH = 7,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_BASE_ADDR        = 0,
   parameter int C_POLL_INTERVAL    = 16,
   parameter int C_TIMEOUT          = 256
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   input  logic                          enable,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [3:0]                    rec_type,
   output logic [63:0]                   rec_order_ref,
   output logic                          rec_side,
   output logic [31:0]                   rec_shares,
   output logic [31:0]                   rec_price,
   output logic [63:0]                   rec_new_order_ref,
   output logic [47:0]                   rec_timestamp,
   output logic [63:0]                   rec_misc,
   output logic [15:0]                   err_count,
   output logic [15:0]                   torn_count,
   output logic                          err_timeout,
   output logic [3:0]                    dbg_state
);

   // Handshakes: a transfer happens on the rising edge where valid && ready.
   // A valid, once raised, stays high with its payload stable until that edge;
   // ready may change freely. Only one AXI read is ever outstanding.

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_POLL_AR   = 4'd1,
      S_POLL_R    = 4'd2,
      S_BURST_AR  = 4'd3,
      S_BURST_R   = 4'd4,
      S_VERIFY_AR = 4'd5,
      S_VERIFY_R  = 4'd6,
      S_CHECK     = 4'd7,
      S_EMIT      = 4'd8
   } state_t;

   localparam logic [3:0]  IDX_VALID = 4'h2;
   localparam logic [3:0]  IDX_FIRST = 4'h3;
   localparam logic [3:0]  IDX_TS_LO = 4'hB;
   localparam logic [3:0]  IDX_LAST  = 4'hE;
   localparam logic [15:0] POLL_LAST = 16'(C_POLL_INTERVAL - 1);
   localparam logic [31:0] TO_LAST   = 32'(C_TIMEOUT - 1);

   function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [3:0] idx);
      logic [31:0] byte_addr;
      byte_addr = 32'(C_BASE_ADDR) + {26'd0, idx, 2'b00};
      return byte_addr[C_M_AXI_ADDR_WIDTH-1:0];
   endfunction

   function automatic state_t r_state_of(input state_t ar_state);
      case (ar_state)
         S_POLL_AR:  return S_POLL_R;
         S_BURST_AR: return S_BURST_R;
         default:    return S_VERIFY_R;
      endcase
   endfunction

   state_t        state;
   logic [15:0]   poll_cnt;
   logic [31:0]   to_cnt;
   logic [3:0]    burst_idx;
   logic          first_rec;
   logic [115:0]  last_key;

   logic [3:0]    sh_type;
   logic [31:0]   sh_oref_lo, sh_oref_hi;
   logic          sh_side;
   logic [31:0]   sh_shares, sh_price;
   logic [31:0]   sh_nref_lo, sh_nref_hi;
   logic [31:0]   sh_ts_lo;
   logic [15:0]   sh_ts_hi;
   logic [31:0]   sh_misc_lo, sh_misc_hi;

   logic          r_hs;
   logic          r_err;
   logic          to_expired;
   logic [115:0]  shadow_key;

   assign M_AXI_ARPROT = 3'b000;
   assign dbg_state    = state;
   assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;
   assign r_err        = (M_AXI_RRESP != 2'b00);
   assign to_expired   = (to_cnt >= TO_LAST);
   assign shadow_key   = {sh_type, sh_oref_hi, sh_oref_lo, sh_ts_hi, sh_ts_lo};

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state             <= S_IDLE;
         poll_cnt          <= 16'd0;
         to_cnt            <= 32'd0;
         burst_idx         <= IDX_FIRST;
         first_rec         <= 1'b1;
         last_key          <= '0;
         M_AXI_ARADDR      <= '0;
         M_AXI_ARVALID     <= 1'b0;
         M_AXI_RREADY      <= 1'b0;
         rec_valid         <= 1'b0;
         rec_type          <= '0;
         rec_order_ref     <= '0;
         rec_side          <= 1'b0;
         rec_shares        <= '0;
         rec_price         <= '0;
         rec_new_order_ref <= '0;
         rec_timestamp     <= '0;
         rec_misc          <= '0;
         err_count         <= 16'd0;
         torn_count        <= 16'd0;
         err_timeout       <= 1'b0;
         sh_type           <= '0;
         sh_oref_lo        <= '0;
         sh_oref_hi        <= '0;
         sh_side           <= 1'b0;
         sh_shares         <= '0;
         sh_price          <= '0;
         sh_nref_lo        <= '0;
         sh_nref_hi        <= '0;
         sh_ts_lo          <= '0;
         sh_ts_hi          <= '0;
         sh_misc_lo        <= '0;
         sh_misc_hi        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!enable) begin
                  poll_cnt <= 16'd0;
               end else if (poll_cnt == POLL_LAST) begin
                  poll_cnt      <= 16'd0;
                  to_cnt        <= 32'd0;
                  M_AXI_ARVALID <= 1'b1;
                  M_AXI_ARADDR  <= addr_of(IDX_VALID);
                  state         <= S_POLL_AR;
               end else begin
                  poll_cnt <= poll_cnt + 16'd1;
               end
            end

            S_POLL_AR, S_BURST_AR, S_VERIFY_AR: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  to_cnt        <= 32'd0;
                  state         <= r_state_of(state);
               end else if (to_expired) begin
                  err_timeout <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end

            S_POLL_R, S_BURST_R, S_VERIFY_R: begin
               if (r_hs) begin
                  M_AXI_RREADY <= 1'b0;
                  to_cnt       <= 32'd0;
                  if (r_err) begin
                     // Any non-OKAY beat poisons the snapshot; restart from a clean poll.
                     if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                     poll_cnt <= 16'd0;
                     state    <= S_IDLE;
                  end else begin
                     case (state)
                        S_POLL_R: begin
                           if (M_AXI_RDATA[0]) begin
                              burst_idx     <= IDX_FIRST;
                              M_AXI_ARVALID <= 1'b1;
                              M_AXI_ARADDR  <= addr_of(IDX_FIRST);
                              state         <= S_BURST_AR;
                           end else begin
                              poll_cnt <= 16'd0;
                              state    <= S_IDLE;
                           end
                        end
                        S_BURST_R: begin
                           case (burst_idx)
                              4'h3:    sh_type    <= M_AXI_RDATA[3:0];
                              4'h4:    sh_oref_lo <= M_AXI_RDATA;
                              4'h5:    sh_oref_hi <= M_AXI_RDATA;
                              4'h6:    sh_side    <= M_AXI_RDATA[0];
                              4'h7:    sh_shares  <= M_AXI_RDATA;
                              4'h8:    sh_price   <= M_AXI_RDATA;
                              4'h9:    sh_nref_lo <= M_AXI_RDATA;
                              4'hA:    sh_nref_hi <= M_AXI_RDATA;
                              4'hB:    sh_ts_lo   <= M_AXI_RDATA;
                              4'hC:    sh_ts_hi   <= M_AXI_RDATA[15:0];
                              4'hD:    sh_misc_lo <= M_AXI_RDATA;
                              4'hE:    sh_misc_hi <= M_AXI_RDATA;
                              default: ;
                           endcase
                           M_AXI_ARVALID <= 1'b1;
                           if (burst_idx == IDX_LAST) begin
                              M_AXI_ARADDR <= addr_of(IDX_TS_LO);
                              state        <= S_VERIFY_AR;
                           end else begin
                              burst_idx    <= burst_idx + 4'd1;
                              M_AXI_ARADDR <= addr_of(burst_idx + 4'd1);
                              state        <= S_BURST_AR;
                           end
                        end
                        default: begin
                           // TS_LO moved under us: the parser latched a new message mid-burst.
                           if (M_AXI_RDATA != sh_ts_lo) begin
                              if (torn_count != 16'hFFFF) torn_count <= torn_count + 16'd1;
                              M_AXI_ARVALID <= 1'b1;
                              M_AXI_ARADDR  <= addr_of(IDX_VALID);
                              state         <= S_POLL_AR;
                           end else begin
                              state <= S_CHECK;
                           end
                        end
                     endcase
                  end
               end else if (to_expired) begin
                  err_timeout <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end

            S_CHECK: begin
               if (first_rec || (shadow_key != last_key)) begin
                  rec_type          <= sh_type;
                  rec_order_ref     <= {sh_oref_hi, sh_oref_lo};
                  rec_side          <= sh_side;
                  rec_shares        <= sh_shares;
                  rec_price         <= sh_price;
                  rec_new_order_ref <= {sh_nref_hi, sh_nref_lo};
                  rec_timestamp     <= {sh_ts_hi, sh_ts_lo};
                  rec_misc          <= {sh_misc_hi, sh_misc_lo};
                  rec_valid         <= 1'b1;
                  state             <= S_EMIT;
               end else begin
                  poll_cnt <= 16'd0;
                  state    <= S_IDLE;
               end
            end

            S_EMIT: begin
               if (rec_valid && rec_ready) begin
                  rec_valid <= 1'b0;
                  last_key  <= {rec_type, rec_order_ref, rec_timestamp};
                  first_rec <= 1'b0;
                  poll_cnt  <= 16'd0;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
